// File: rtl/seq_detector_mealy_param.sv
// Parametrised Mealy serial pattern detector with don't-care mask and overlap select.
// Optional saturating match counter on the match_count port when MATCH_COUNT_EN is defined.
module seq_detector_mealy_param #(
  parameter int unsigned        PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = 3'b101,
  parameter int unsigned        CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               x,
  input  logic               x_valid,
  input  logic               ovl_en,
  input  logic [PAT_LEN-1:0] care_mask,
  output logic               y
`ifdef MATCH_COUNT_EN
  ,
  output logic [CNT_W-1:0]   match_count
`endif
);

  localparam int unsigned        FillW   = $clog2(PAT_LEN);
  localparam logic [FillW-1:0]   FillMax = FillW'(PAT_LEN - 1);

  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic [PAT_LEN-1:0] win;
  logic               accept;

  assign win    = {hist_q, x};
  assign accept = x_valid & ~clr;

  always_comb begin
    y = accept & ~rst & (fill_q == FillMax) & (((win ^ PATTERN) & care_mask) == '0);
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (x_valid) begin
      // Low PAT_LEN-1 bits of the window are exactly the shifted history.
      hist_d = win[PAT_LEN-2:0];
      if (y && !ovl_en) begin
        fill_d = '0;
      end else if (fill_q != FillMax) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

`ifdef MATCH_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (y && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign match_count = count_q;
`endif

endmodule

// File: tb/tb_seq_detector_mealy_param.sv
// Table-driven bench for seq_detector_mealy_param; a second instance with CNT_W=2
// shares the stimulus to exercise counter saturation when MATCH_COUNT_EN is defined.
module tb_seq_detector_mealy_param;

  logic       clk = 1'b0;
  logic       rst, clr, x, x_valid, ovl_en;
  logic [2:0] care_mask;
  logic       y, y_sat;
`ifdef MATCH_COUNT_EN
  logic [15:0] match_count;
  logic [1:0]  sat_count;
`endif

  always #5 clk = ~clk;

  seq_detector_mealy_param #(
    .PAT_LEN(3),
    .PATTERN(3'b101),
    .CNT_W  (16)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .x          (x),
    .x_valid    (x_valid),
    .ovl_en     (ovl_en),
    .care_mask  (care_mask),
    .y          (y)
`ifdef MATCH_COUNT_EN
    ,
    .match_count(match_count)
`endif
  );

  seq_detector_mealy_param #(
    .PAT_LEN(3),
    .PATTERN(3'b101),
    .CNT_W  (2)
  ) u_sat (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .x          (x),
    .x_valid    (x_valid),
    .ovl_en     (ovl_en),
    .care_mask  (care_mask),
    .y          (y_sat)
`ifdef MATCH_COUNT_EN
    ,
    .match_count(sat_count)
`endif
  );

  typedef struct {
    logic       r;
    logic       c;
    logic       v;
    logic       x;
    logic       o;
    logic [2:0] m;
    logic       ey;
    int         ecnt;  // count expected before this row's edge, -1 = unchecked
  } vec_t;

  vec_t vecs[$];
  logic exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void add(logic r, logic c, logic v, logic xb, logic o, logic [2:0] m,
                              logic ey, int ecnt);
    vec_t t;
    t = '{r: r, c: c, v: v, x: xb, o: o, m: m, ey: ey, ecnt: ecnt};
    vecs.push_back(t);
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  int stream[20] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1};
  int ea[20]     = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
  int eb[20]     = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};

  initial begin
    logic e;
    string nm;
    rst = 1'b1; clr = 1'b0; x = 1'b0; x_valid = 1'b0; ovl_en = 1'b1; care_mask = 3'b111;

    // Reset held, valid completing-looking bits must not flag
    add(1, 0, 1, 1, 1, 3'b111, 0, 0);
    add(1, 0, 1, 1, 1, 3'b111, 0, 0);
    // Overlapping stream
    for (int i = 0; i < 20; i++) add(0, 0, 1, stream[i][0], 1, 3'b111, ea[i][0], -1);
    add(0, 1, 1, 1, 1, 3'b111, 0, 5);
    // Non-overlapping stream
    for (int i = 0; i < 20; i++) add(0, 0, 1, stream[i][0], 0, 3'b111, eb[i][0], (i == 0) ? 0 : -1);
    add(0, 1, 1, 1, 1, 3'b111, 0, 4);
    // Gap tolerance: x held at 1 during gap so only x_valid suppresses y
    add(0, 0, 1, 1, 1, 3'b111, 0, 0);
    add(0, 0, 1, 0, 1, 3'b111, 0, -1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 1, 3'b111, 0, -1);
    add(0, 0, 1, 1, 1, 3'b111, 1, -1);
    // Don't-care middle bit
    add(0, 1, 1, 0, 1, 3'b101, 0, 1);
    add(0, 0, 1, 1, 1, 3'b101, 0, -1);
    add(0, 0, 1, 1, 1, 3'b101, 0, -1);
    add(0, 0, 1, 1, 1, 3'b101, 1, -1);
    add(0, 1, 1, 0, 1, 3'b101, 0, 2);
    add(0, 0, 1, 1, 1, 3'b101, 0, -1);
    add(0, 0, 1, 1, 1, 3'b101, 0, -1);
    add(0, 0, 1, 0, 1, 3'b101, 0, -1);
    // All don't-care: every bit after the fill matches
    add(0, 1, 1, 1, 1, 3'b000, 0, 2);
    add(0, 0, 1, 0, 1, 3'b000, 0, -1);
    add(0, 0, 1, 1, 1, 3'b000, 0, -1);
    add(0, 0, 1, 0, 1, 3'b000, 1, -1);
    add(0, 0, 1, 1, 1, 3'b000, 1, -1);
    // Clear coinciding with a completing bit
    add(0, 1, 1, 0, 1, 3'b111, 0, 4);
    add(0, 0, 1, 1, 1, 3'b111, 0, 0);
    add(0, 0, 1, 0, 1, 3'b111, 0, -1);
    add(0, 1, 1, 1, 1, 3'b111, 0, -1);
    add(0, 0, 1, 1, 1, 3'b111, 0, 0);
    // Reset mid-sequence
    add(0, 1, 1, 0, 1, 3'b111, 0, -1);
    add(0, 0, 1, 1, 1, 3'b111, 0, -1);
    add(0, 0, 1, 0, 1, 3'b111, 0, -1);
    add(1, 0, 1, 1, 1, 3'b111, 0, 0);
    add(0, 0, 1, 1, 1, 3'b111, 0, 0);
    add(0, 0, 1, 1, 1, 3'b111, 0, -1);
    add(0, 0, 1, 0, 1, 3'b111, 0, -1);
    add(0, 0, 1, 1, 1, 3'b111, 1, -1);
    add(0, 0, 0, 0, 1, 3'b111, 0, 1);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst = vecs[i].r; clr = vecs[i].c; x_valid = vecs[i].v; x = vecs[i].x;
      ovl_en = vecs[i].o; care_mask = vecs[i].m;
      exp_q.push_back(vecs[i].ey);
      @(negedge clk);
      e = exp_q.pop_front();
      nm = $sformatf("y[row %0d]", i);
      check(nm, {31'b0, y}, {31'b0, e});
      nm = $sformatf("y_sat[row %0d]", i);
      check(nm, {31'b0, y_sat}, {31'b0, e});
`ifdef MATCH_COUNT_EN
      if (vecs[i].ecnt >= 0) begin
        nm = $sformatf("match_count[row %0d]", i);
        check(nm, {16'b0, match_count}, vecs[i].ecnt);
        nm = $sformatf("sat_count[row %0d]", i);
        check(nm, {30'b0, sat_count}, (vecs[i].ecnt > 3) ? 3 : vecs[i].ecnt);
      end
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
